// File: rtl/adder_pkg.sv
// Shared definitions for the wide-adder result path: default widths,
// the beat-count helper and the read-side state encoding.
package adder_pkg;

   localparam int DEFAULT_W    = 256;
   localparam int DEFAULT_BEAT = 32;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } rd_state_e;

   function automatic int nbeats(input int w, input int beat);
      return w / beat;
   endfunction

endpackage

// File: rtl/adder_result_serializer_fifo.sv
// Synchronous result FIFO; dout is the head entry read combinationally
// from registered storage, so a newly written entry is visible next cycle.
module result_fifo #(
   parameter int WIDTH = 257,
   parameter int DEPTH = 4,
   localparam int LW   = $clog2(DEPTH + 1),
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [LW-1:0]    level,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]    level_q;

   // Explicit wrap keeps non-power-of-two depths correct.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign level = level_q;
   assign full  = (level_q == LW'(DEPTH));
   assign empty = (level_q == '0);

endmodule

// File: rtl/adder_result_serializer.sv
// Buffers {c_out, sum} results from a non-backpressured adder and streams
// each one out as NB beats, least-significant beat first.
module adder_result_serializer
   import adder_pkg::*;
#(
   parameter int W     = DEFAULT_W,
   parameter int BEAT  = DEFAULT_BEAT,
   parameter int DEPTH = 4,
   localparam int NB   = nbeats(W, BEAT),
   localparam int IW   = (NB > 1) ? $clog2(NB) : 1,
   localparam int LW   = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            res_valid,
   input  logic [W-1:0]    res_sum,
   input  logic            res_cout,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [BEAT-1:0] out_data,
   output logic [IW-1:0]   out_idx,
   output logic            out_last,
   output logic            out_cout,
   output logic [LW-1:0]   fifo_level,
   output logic            almost_full,
   output logic            overflow
);

   generate
      if ((W % BEAT) != 0) begin : g_bad_beat
         $error("adder_result_serializer: W must be a multiple of BEAT");
      end
      if (DEPTH < 2) begin : g_bad_depth
         $error("adder_result_serializer: DEPTH must be at least 2");
      end
   endgenerate

   rd_state_e              state_q;
   logic [IW-1:0]          beat_q;
   logic                   overflow_q;
   logic [W:0]             head;
   logic                   fifo_full, fifo_empty;
   logic                   accept, pop_last;
   logic [NB-1:0][BEAT-1:0] head_beats;

   assign out_valid = (state_q == ST_SEND);
   assign out_last  = (beat_q == IW'(NB - 1));
   assign pop_last  = out_valid && out_ready && out_last;
   // A full FIFO still takes a result when the head leaves in the same cycle.
   assign accept    = res_valid && (!fifo_full || pop_last);

   result_fifo #(.WIDTH(W + 1), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .pop   (pop_last),
      .din   ({res_cout, res_sum}),
      .dout  (head),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         beat_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (res_valid && !accept) overflow_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (accept || !fifo_empty) state_q <= ST_SEND;
            end
            ST_SEND: begin
               if (out_ready) begin
                  if (out_last) begin
                     beat_q <= '0;
                     if (fifo_level == LW'(1) && !accept) state_q <= ST_IDLE;
                  end else begin
                     beat_q <= beat_q + 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign head_beats  = head[W-1:0];
   assign out_idx     = beat_q;
   assign out_data    = out_valid ? head_beats[beat_q] : '0;
   assign out_cout    = out_valid & head[W];
   assign almost_full = (fifo_level >= LW'(DEPTH - 1));
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_adder_result_serializer.sv
// Directed bench for adder_result_serializer at W=256, BEAT=32, DEPTH=4.
module tb_adder_result_serializer;

   localparam int W = 256, BEAT = 32, DEPTH = 4, NB = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            res_valid;
   logic [W-1:0]    res_sum;
   logic            res_cout;
   logic            out_valid;
   logic            out_ready;
   logic [BEAT-1:0] out_data;
   logic [2:0]      out_idx;
   logic            out_last;
   logic            out_cout;
   logic [2:0]      fifo_level;
   logic            almost_full;
   logic            overflow;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   adder_result_serializer #(.W(W), .BEAT(BEAT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .res_valid(res_valid), .res_sum(res_sum),
      .res_cout(res_cout), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
      .out_cout(out_cout), .fifo_level(fifo_level),
      .almost_full(almost_full), .overflow(overflow)
   );

   function automatic logic [W-1:0] mk(input logic [31:0] base);
      logic [W-1:0] s;
      for (int i = 0; i < NB; i++) s[i*BEAT +: BEAT] = base + 32'(i);
      return s;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; res_valid = 1'b0; res_sum = '0; res_cout = 1'b0; out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic push(input logic [31:0] base, input logic c);
      res_valid = 1'b1; res_sum = mk(base); res_cout = c;
      step();
      res_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({out_valid, out_data, out_idx, out_last, out_cout, fifo_level, almost_full, overflow} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got valid=%0b data=%h idx=%0d last=%0b cout=%0b lvl=%0d af=%0b ovf=%0b, want all 0",
                  out_valid, out_data, out_idx, out_last, out_cout, fifo_level, almost_full, overflow);
      end
   endtask

   task automatic test_single();
      do_reset();
      out_ready = 1'b1;
      push(32'h1000_0000, 1'b1);
      for (int i = 0; i < NB; i++) begin
         total++;
         if (out_valid !== 1'b1 || out_data !== 32'h1000_0000 + 32'(i) || out_idx !== 3'(i) ||
             out_last !== (i == NB - 1) || out_cout !== 1'b1) begin
            bad++;
            $display("FAIL single_beat%0d: got v=%0b data=%h idx=%0d last=%0b cout=%0b, want v=1 data=%h idx=%0d last=%0b cout=1",
                     i, out_valid, out_data, out_idx, out_last, out_cout, 32'h1000_0000 + 32'(i), i, i == NB - 1);
         end
         step();
      end
      total++;
      if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
         bad++;
         $display("FAIL single_drain: got v=%0b lvl=%0d, want v=0 lvl=0", out_valid, fifo_level);
      end
   endtask

   task automatic test_stall();
      do_reset();
      push(32'h1000_0000, 1'b1);
      for (int c = 0; c < 2 * NB; c++) begin
         out_ready = c[0];
         total++;
         if (out_valid !== 1'b1 || out_data !== 32'h1000_0000 + 32'(c / 2) || out_idx !== 3'(c / 2)) begin
            bad++;
            $display("FAIL stall_cyc%0d: got v=%0b data=%h idx=%0d, want v=1 data=%h idx=%0d",
                     c, out_valid, out_data, out_idx, 32'h1000_0000 + 32'(c / 2), c / 2);
         end
         step();
      end
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL stall_done: got v=%0b, want 0", out_valid);
      end
   endtask

   task automatic test_overflow();
      logic [2:0] exp_lvl [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      logic       exp_af  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic       exp_ov  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      for (int k = 0; k < 5; k++) begin
         push(32'h0100_0000 * (k + 1), k[0]);
         total++;
         if (fifo_level !== exp_lvl[k] || almost_full !== exp_af[k] || overflow !== exp_ov[k]) begin
            bad++;
            $display("FAIL ovf_push%0d: got lvl=%0d af=%0b ovf=%0b, want lvl=%0d af=%0b ovf=%0b",
                     k, fifo_level, almost_full, overflow, exp_lvl[k], exp_af[k], exp_ov[k]);
         end
      end
      out_ready = 1'b1;
      for (int c = 0; c < 4 * NB; c++) begin
         total++;
         if (out_valid !== 1'b1 || out_data !== 32'h0100_0000 * (c / NB + 1) + 32'(c % NB) ||
             out_cout !== logic'((c / NB) % 2)) begin
            bad++;
            $display("FAIL ovf_stream%0d: got v=%0b data=%h cout=%0b, want v=1 data=%h cout=%0b",
                     c, out_valid, out_data, out_cout, 32'h0100_0000 * (c / NB + 1) + 32'(c % NB), (c / NB) % 2);
         end
         step();
      end
      total++;
      if (out_valid !== 1'b0 || fifo_level !== 3'd0 || overflow !== 1'b1) begin
         bad++;
         $display("FAIL ovf_end: got v=%0b lvl=%0d ovf=%0b, want v=0 lvl=0 ovf=1", out_valid, fifo_level, overflow);
      end
   endtask

   task automatic test_full_pop_write();
      do_reset();
      for (int k = 0; k < 4; k++) push(32'h0A00_0000 + 32'h0010_0000 * k, 1'b0);
      out_ready = 1'b1;
      for (int i = 0; i < NB - 1; i++) step();
      total++;
      if (out_last !== 1'b1 || fifo_level !== 3'd4) begin
         bad++;
         $display("FAIL fpw_pre: got last=%0b lvl=%0d, want last=1 lvl=4", out_last, fifo_level);
      end
      push(32'h0A40_0000, 1'b1);
      total++;
      if (fifo_level !== 3'd4 || overflow !== 1'b0 || out_idx !== 3'd0) begin
         bad++;
         $display("FAIL fpw_same_cycle: got lvl=%0d ovf=%0b idx=%0d, want lvl=4 ovf=0 idx=0", fifo_level, overflow, out_idx);
      end
      for (int c = 0; c < 4 * NB; c++) begin
         total++;
         if (out_valid !== 1'b1 || out_data !== 32'h0A10_0000 + 32'h0010_0000 * (c / NB) + 32'(c % NB) ||
             out_cout !== (c / NB == 3)) begin
            bad++;
            $display("FAIL fpw_stream%0d: got v=%0b data=%h cout=%0b, want v=1 data=%h cout=%0b", c, out_valid, out_data,
                     out_cout, 32'h0A10_0000 + 32'h0010_0000 * (c / NB) + 32'(c % NB), c / NB == 3);
         end
         step();
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int k = 0; k < 5; k++) push(32'h0300_0000, 1'b1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();
      total++;
      if (out_idx !== 3'd3 || overflow !== 1'b1) begin
         bad++;
         $display("FAIL mrst_pre: got idx=%0d ovf=%0b, want idx=3 ovf=1", out_idx, overflow);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++;
      if (out_valid !== 1'b0 || fifo_level !== 3'd0 || out_idx !== 3'd0 || overflow !== 1'b0) begin
         bad++;
         $display("FAIL mrst_after: got v=%0b lvl=%0d idx=%0d ovf=%0b, want all 0", out_valid, fifo_level, out_idx, overflow);
      end
      push(32'h0500_0000, 1'b0);
      for (int i = 0; i < NB; i++) begin
         total++;
         if (out_valid !== 1'b1 || out_idx !== 3'(i) || out_data !== 32'h0500_0000 + 32'(i)) begin
            bad++;
            $display("FAIL mrst_fresh%0d: got v=%0b idx=%0d data=%h, want v=1 idx=%0d data=%h",
                     i, out_valid, out_idx, out_data, i, 32'h0500_0000 + 32'(i));
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      out_ready = 1'b1;
      push(32'h0600_0000, 1'b0);
      for (int c = 0; c < 2 * NB; c++) begin
         if (c == 0) begin
            res_valid = 1'b1; res_sum = mk(32'h0700_0000); res_cout = 1'b1;
         end else begin
            res_valid = 1'b0;
         end
         total++;
         if (out_valid !== 1'b1 || out_idx !== 3'(c % NB) ||
             out_data !== ((c < NB) ? 32'h0600_0000 : 32'h0700_0000) + 32'(c % NB) || out_cout !== (c >= NB)) begin
            bad++;
            $display("FAIL b2b_cyc%0d: got v=%0b idx=%0d data=%h cout=%0b, want v=1 idx=%0d data=%h cout=%0b",
                     c, out_valid, out_idx, out_data, out_cout, c % NB,
                     ((c < NB) ? 32'h0600_0000 : 32'h0700_0000) + 32'(c % NB), c >= NB);
         end
         step();
      end
      total++;
      if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
         bad++;
         $display("FAIL b2b_end: got v=%0b lvl=%0d, want v=0 lvl=0", out_valid, fifo_level);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stall();
      test_overflow();
      test_full_pop_write();
      test_mid_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
